// File: rtl/c_drain_if.sv
// Host read-path stream between the C drain stage and its consumer.
// The master drives a data word with a valid flag; the slave answers with ready.
// A word is transferred on every rising edge where valid and ready are both high.
interface c_drain_if #(
    parameter int DATAW = 64
) ();
    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/c_drain.sv
// c_drain: result-drain stage behind the systolic array.
// Walks the C rows one at a time, captures each row and streams it to the host
// as DATAW-bit words, column 0 in the least significant bits.
// Optional build macro C_DRAIN_SAT8_EN: every entry is saturated to signed
// 8 bits and packed one byte per column, so each row needs fewer words.
module c_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8,
    parameter int DATAW  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DIM)-1:0]    crow,
    input  logic [DIM*BITS_C-1:0]     cin,
    c_drain_if.master                 outBus
);

`ifdef C_DRAIN_SAT8_EN
    localparam int EW = 8;
`else
    localparam int EW = BITS_C;
`endif
    localparam int ROWW  = DIM * EW;
    localparam int WPR   = ROWW / DATAW;
    localparam int IDXW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int CROWW = $clog2(DIM);

    localparam logic [CROWW-1:0] LAST_ROW  = CROWW'(DIM - 1);
    localparam logic [IDXW-1:0]  LAST_WORD = IDXW'(WPR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            stateReg, stateNext;
    logic [CROWW-1:0]  crowReg, crowNext;
    logic [IDXW-1:0]   idxReg, idxNext;
    logic [ROWW-1:0]   rowReg, rowNext;
    logic [ROWW-1:0]   rowPacked;
    logic              accept;

    // Per-column shaping of the incoming row before it is captured.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_col
`ifdef C_DRAIN_SAT8_EN
            localparam logic signed [BITS_C-1:0] SAT_MAX = BITS_C'(127);
            localparam logic signed [BITS_C-1:0] SAT_MIN = -BITS_C'(128);
            logic signed [BITS_C-1:0] entry;
            assign entry = $signed(cin[gi*BITS_C +: BITS_C]);
            assign rowPacked[gi*8 +: 8] = (entry > SAT_MAX) ? 8'h7F :
                                          (entry < SAT_MIN) ? 8'h80 :
                                          entry[7:0];
`else
            assign rowPacked[gi*BITS_C +: BITS_C] = cin[gi*BITS_C +: BITS_C];
`endif
        end
    endgenerate

    assign accept = (stateReg == SEND) && outBus.out_ready;

    // State, row pointer, word pointer and row buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            crowReg  <= '0;
            idxReg   <= '0;
            rowReg   <= '0;
        end else begin
            stateReg <= stateNext;
            crowReg  <= crowNext;
            idxReg   <= idxNext;
            rowReg   <= rowNext;
        end
    end

    // Next-state logic: load a row, send its words, advance or finish.
    always_comb begin
        stateNext = stateReg;
        crowNext  = crowReg;
        idxNext   = idxReg;
        rowNext   = rowReg;
        unique case (stateReg)
            IDLE: begin
                if (start) begin
                    crowNext  = '0;
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                rowNext   = rowPacked;
                idxNext   = '0;
                stateNext = SEND;
            end
            SEND: begin
                if (accept) begin
                    if (idxReg != LAST_WORD) begin
                        idxNext = idxReg + IDXW'(1);
                    end else if (crowReg == LAST_ROW) begin
                        crowNext  = '0;
                        stateNext = DONE;
                    end else begin
                        crowNext  = crowReg + CROWW'(1);
                        stateNext = LOAD;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state so they are glitch-free.
    always_comb begin
        busy             = (stateReg != IDLE);
        done             = (stateReg == DONE);
        crow             = crowReg;
        outBus.out_valid = (stateReg == SEND);
        outBus.out_data  = '0;
        if (stateReg == SEND) begin
            outBus.out_data = rowReg[idxReg*DATAW +: DATAW];
        end
    end

endmodule

// File: tb/tb_c_drain.sv
module tb_c_drain;

    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int DATAW  = 64;
`ifdef C_DRAIN_SAT8_EN
    localparam int EW = 8;
`else
    localparam int EW = BITS_C;
`endif
    localparam int WPR = DIM * EW / DATAW;
    localparam int CPW = DATAW / EW;
    localparam int NOM_DONE = 1 + DIM * (1 + WPR);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [2:0]             crow;
    logic [DIM*BITS_C-1:0]  cin;

    c_drain_if #(.DATAW(DATAW)) bus ();

    c_drain #(.BITS_C(BITS_C), .DIM(DIM), .DATAW(DATAW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .crow   (crow),
        .cin    (cin),
        .outBus (bus.master)
    );

    always #5 clk = ~clk;

    logic [BITS_C-1:0] cmat [DIM][DIM];

    always_comb begin
        cin = '0;
        for (int c = 0; c < DIM; c++) cin[c*BITS_C +: BITS_C] = cmat[crow][c];
    end

    int tests = 0;
    int fails = 0;

    logic [DATAW-1:0] expQ[$];
    int               expRowQ[$];
    logic [DATAW-1:0] obsQ[$];
    int               lastDoneCyc;

    task automatic chk(input string tag, input bit ok,
                       input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input logic [BITS_C-1:0] v);
        int s;
        s = $signed(v);
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    task automatic buildExpected();
        logic [DATAW-1:0] w;
        logic [DATAW-1:0] v;
        expQ.delete();
        expRowQ.delete();
        for (int r = 0; r < DIM; r++) begin
            for (int wi = 0; wi < WPR; wi++) begin
                w = '0;
                for (int k = 0; k < CPW; k++) begin
`ifdef C_DRAIN_SAT8_EN
                    v = DATAW'(sat8(cmat[r][wi*CPW+k]));
`else
                    v = DATAW'(cmat[r][wi*CPW+k]);
`endif
                    w = w | (v << (k * EW));
                end
                expQ.push_back(w);
                expRowQ.push_back(r);
            end
        end
    endtask

    task automatic fillRamp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                cmat[r][c] = BITS_C'(r * 16 + c);
    endtask

    task automatic fillRandom();
        int sel;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                sel = int'($urandom_range(0, 3));
                if (sel == 0) cmat[r][c] = BITS_C'($urandom_range(0, 255)) - BITS_C'(128);
                else cmat[r][c] = BITS_C'($urandom);
            end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic runDrain(input int readyMode, input int stallWord, input int stallLen,
                            input int extraStart, input int abortCyc, input string name);
        int cyc, accepted, stalls, doneCnt, doneCyc, firstValid, stallLeft;
        logic prevValid, prevReady, aborted;
        cyc = 0; accepted = 0; stalls = 0; doneCnt = 0; doneCyc = -1;
        firstValid = -1; stallLeft = stallLen; prevValid = 0; prevReady = 0;
        aborted = 0;
        obsQ.delete();
        buildExpected();
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (doneCyc < 0)
                chk({name, " busy"}, busy === 1'b1, DATAW'(busy), DATAW'(1));
            if (prevValid && !prevReady)
                chk({name, " valid_hold"}, bus.out_valid === 1'b1, DATAW'(bus.out_valid), DATAW'(1));
            if (bus.out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                if (accepted < expQ.size()) begin
                    chk({name, " data"}, bus.out_data === expQ[accepted], bus.out_data, expQ[accepted]);
                    chk({name, " crow"}, int'(crow) === expRowQ[accepted],
                        DATAW'(crow), DATAW'(expRowQ[accepted]));
                end else begin
                    chk({name, " extra_word"}, accepted === expQ.size(),
                        DATAW'(accepted), DATAW'(expQ.size()));
                end
            end
            case (readyMode)
                1: begin
                    if (bus.out_valid && accepted == stallWord && stallLeft > 0) begin
                        bus.out_ready = 1'b0;
                        stallLeft--;
                    end else bus.out_ready = 1'b1;
                end
                2: bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b1;
            endcase
            if (bus.out_valid && bus.out_ready) begin
                obsQ.push_back(bus.out_data);
                accepted++;
            end
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (doneCyc >= 0) break;
            start = (cyc == extraStart);
            rst = (cyc == abortCyc);
            prevValid = bus.out_valid;
            prevReady = bus.out_ready;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        bus.out_ready = 1'b1;
        if (aborted) begin
            chk({name, " abort_busy"}, busy === 1'b0, DATAW'(busy), DATAW'(0));
            chk({name, " abort_valid"}, bus.out_valid === 1'b0, DATAW'(bus.out_valid), DATAW'(0));
            chk({name, " abort_done"}, done === 1'b0, DATAW'(done), DATAW'(0));
            chk({name, " abort_done_cnt"}, doneCnt === 0, DATAW'(doneCnt), DATAW'(0));
        end else begin
            chk({name, " done_cnt"}, doneCnt === 1, DATAW'(doneCnt), DATAW'(1));
            chk({name, " words"}, accepted === expQ.size(), DATAW'(accepted), DATAW'(expQ.size()));
            chk({name, " first_valid"}, firstValid === 2, DATAW'(firstValid), DATAW'(2));
            chk({name, " done_cycle"}, doneCyc === NOM_DONE + stalls,
                DATAW'(doneCyc), DATAW'(NOM_DONE + stalls));
            chk({name, " done_valid"}, bus.out_valid === 1'b0, DATAW'(bus.out_valid), DATAW'(0));
            @(posedge clk); #1;
            chk({name, " post_busy"}, busy === 1'b0, DATAW'(busy), DATAW'(0));
            chk({name, " post_done"}, done === 1'b0, DATAW'(done), DATAW'(0));
        end
        lastDoneCyc = doneCyc;
    endtask

    initial begin
        logic [DATAW-1:0] k0;
        logic [DATAW-1:0] k15;
        rst = 1'b1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        lastDoneCyc = -1;
        fillRamp();

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst busy", busy === 1'b0, DATAW'(busy), DATAW'(0));
            chk("rst valid", bus.out_valid === 1'b0, DATAW'(bus.out_valid), DATAW'(0));
            chk("rst done", done === 1'b0, DATAW'(done), DATAW'(0));
            chk("rst crow", crow === 3'd0, DATAW'(crow), DATAW'(0));
            chk("rst data", bus.out_data === 64'd0, bus.out_data, DATAW'(0));
        end
        rst = 1'b0;
        start = 1'b0;
        idleCycles(2);
        chk("idle busy", busy === 1'b0, DATAW'(busy), DATAW'(0));
        chk("idle valid", bus.out_valid === 1'b0, DATAW'(bus.out_valid), DATAW'(0));
        chk("idle crow", crow === 3'd0, DATAW'(crow), DATAW'(0));

`ifdef C_DRAIN_SAT8_EN
        cmat[0][0] = 16'd300;  cmat[0][1] = -16'sd300; cmat[0][2] = 16'd127;
        cmat[0][3] = -16'sd128; cmat[0][4] = 16'd5;    cmat[0][5] = -16'sd1;
        cmat[0][6] = 16'd0;    cmat[0][7] = 16'd128;
        runDrain(0, 0, 0, -1, -1, "sat8");
        k0 = 64'h7F00_FF05_807F_807F;
        if (obsQ.size() > 0) chk("sat8 word0", obsQ[0] === k0, obsQ[0], k0);
        chk("sat8 done17", lastDoneCyc === 17, DATAW'(lastDoneCyc), DATAW'(17));
        fillRamp();
`else
        runDrain(0, 0, 0, -1, -1, "full");
        k0 = 64'h0003_0002_0001_0000;
        k15 = 64'h0077_0076_0075_0074;
        if (obsQ.size() == 16) begin
            chk("full word0", obsQ[0] === k0, obsQ[0], k0);
            chk("full word15", obsQ[15] === k15, obsQ[15], k15);
        end else chk("full nwords", obsQ.size() === 16, DATAW'(obsQ.size()), DATAW'(16));
        chk("full done25", lastDoneCyc === 25, DATAW'(lastDoneCyc), DATAW'(25));
`endif
        idleCycles(2);

        runDrain(1, 3, 5, -1, -1, "bp");
`ifndef C_DRAIN_SAT8_EN
        chk("bp done30", lastDoneCyc === 30, DATAW'(lastDoneCyc), DATAW'(30));
        k0 = 64'h0017_0016_0015_0014;
        if (obsQ.size() > 3) chk("bp word3", obsQ[3] === k0, obsQ[3], k0);
`endif
        idleCycles(2);

        runDrain(0, 0, 0, -1, 10, "abort");
        idleCycles(1);
        runDrain(0, 0, 0, -1, -1, "restart");
`ifndef C_DRAIN_SAT8_EN
        k0 = 64'h0003_0002_0001_0000;
        if (obsQ.size() > 0) chk("restart word0", obsQ[0] === k0, obsQ[0], k0);
`endif
        idleCycles(2);

        runDrain(0, 0, 0, 6, -1, "busy_start");
        idleCycles(2);

        for (int t = 0; t < 6; t++) begin
            fillRandom();
            runDrain(2, 0, 0, int'($urandom_range(1, 20)), -1, "rand");
            idleCycles(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/c_drain.md
Name: c_drain

Overview:
- Result-drain stage directly downstream of the systolic array.
- After a multiply completes, it walks the array's C rows, selecting each row in turn, and captures that row's outputs.
- It slices each captured row into DATAW-bit words and presents them to the host read path over a valid/ready handshake.
- The TPU control FSM starts it and waits for its done pulse.

Parameters:
- BITS_C, 16: width of one signed accumulator entry of C.
- DIM, 8: array dimension; C has DIM rows of DIM entries.
- DATAW, 64: host data word width. DIM*BITS_C must be an integer multiple of DATAW.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a drain; ignored unless the FSM is in IDLE.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when the final word has been accepted.
- crow  output  $clog2(DIM)  row select driven to the systolic array's Crow input.
- cin  input  DIM*BITS_C  systolic array Cout for the row on crow; combinational from crow.
- out_data  output  DATAW  current output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.

Behaviour:
- Reset (synchronous, active-high, checked at the clock edge):
  - state=IDLE, crow=0, word index=0.
  - busy=0, done=0, out_valid=0, out_data=0, row register=0.
  - Reset asserted mid-drain aborts immediately with no done pulse; any partially sent row is discarded.
- Definition: WPR = DIM*BITS_C/DATAW words per row (2 at defaults).
- States and transitions:
  - IDLE: if start, set crow=0 and go to LOAD; otherwise stay.
  - LOAD (1 cycle): register cin into the row register, clear the word index, go to SEND.
  - SEND:
    - out_valid=1; out_data = row register bits [idx*DATAW +: DATAW]. Word 0 holds columns 0..3 at defaults, with column 0 in the LSBs.
    - On acceptance with idx < WPR-1: idx++.
    - On acceptance with idx = WPR-1: if crow = DIM-1, go to DONE; otherwise crow++ and go to LOAD.
  - DONE (1 cycle): done=1, out_valid=0, then go to IDLE. crow returns to 0.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, idx and crow hold exactly.
  - out_valid never drops without an acceptance, except on reset.
  - out_valid is 0 in IDLE, LOAD and DONE.
- Latency, with out_ready tied high and start sampled at cycle 0:
  - LOAD at cycle 1; first valid word at cycle 2.
  - Row r is loaded at cycle 1+r*(1+WPR).
  - done is high at cycle 1+DIM*(1+WPR), which is 25 at defaults.
- Simultaneous events:
  - start in a non-IDLE state is dropped, not queued.
  - start in the same cycle as rst is ignored.
- Data is passed bit-exact; there is no sign manipulation unless the optional feature is enabled.

Optional Feature:
- Macro: C_DRAIN_SAT8_EN.
- Defined:
  - Each BITS_C entry is treated as signed and saturated to signed 8-bit: >127 becomes 0x7F, < -128 becomes 0x80, all other values pass through unchanged.
  - Saturated entries are packed 8 bits per column in column order. WPR becomes DIM*8/DATAW (1 at defaults).
  - done is high at cycle 1+DIM*2 = 17 with out_ready tied high.
- Undefined: full BITS_C entries are sent as described above. The port list is identical either way.

Test Plan:
- Reset/idle: hold rst for 2 cycles with start=1 → busy=0, out_valid=0, done=0, crow=0 throughout and after release.
- Full drain, out_ready=1, C[r][c]=r*16+c → 16 words.
  - Word 0 = 0x0003_0002_0001_0000.
  - Word 15 = 0x0077_0076_0075_0074.
  - done pulses exactly at cycle 25; crow steps 0..7.
- Backpressure: drop out_ready for 5 cycles at word 3 → out_data stays 0x0017_0016_0015_0014 and out_valid=1 for all 5 cycles; no word is lost or duplicated; done is delayed by 5 cycles (cycle 30).
- Abort: assert rst at cycle 10 mid-drain, then issue start → no done from the first run; the second run restarts at row 0, word 0, with correct data.
- Start while busy: pulse start at cycles 0 and 6 → single drain, exactly 16 words, one done pulse.
- C_DRAIN_SAT8_EN: row 0 = {300, -300, 127, -128, 5, -1, 0, 128} for columns 0..7 → word = 0x7F00_FF05_807F_807F; done at cycle 17.
